// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with terminal-count strobe, one-shot or auto-reload.
// A load always wins over counting; terminal count is the transition out of 1.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc_pulse,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      // A zero load parks the timer instead of producing an instant terminal event.
      cnt_d    = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? COUNT : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        COUNT: begin
          if (enable) begin
            if (cnt_q == ONE) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = EXPIRED;
              end
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        EXPIRED: cnt_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign counter_out = cnt_q;
  assign tc_pulse    = tc_q;
  assign busy        = (state_q == COUNT);
  assign expired     = (state_q == EXPIRED);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counter/timer, the counting-down counterpart to the team's 4-bit up-counter. It loads a start value, decrements once per enabled clock and flags terminal count. It runs one-shot or auto-reload (periodic tick). It is used as a timeout/interval generator beside the up-counter in the same clock domain.

Parameters:
WIDTH, 4, bit width of counter, load value and reload register

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clock
enable  input  1  count enable; decrement permitted only when 1
load  input  1  synchronous load strobe; captures load_value
load_value  input  WIDTH  start/reload value
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled every cycle
counter_out  output  WIDTH  current count (registered)
tc_pulse  output  1  one-cycle terminal-count strobe (registered)
busy  output  1  1 while in COUNT state
expired  output  1  1 while in EXPIRED state

Behaviour:
- Interface decided: one clock (clock); reset asynchronous, active-low (reset). All other inputs are synchronous to rising edge of clock.
- Reset (reset=0, async, any time incl. mid-count):
  - counter_out=0, reload_reg=0, state=IDLE.
  - tc_pulse=0, busy=0, expired=0.
  - Registers held while reset=0; normal operation from first rising edge after release.
- States: IDLE, COUNT, EXPIRED. busy=(state==COUNT), expired=(state==EXPIRED), both registered/decoded from state register.
- Priority per edge: reset > load > count logic.
- load=1 (any state, enable ignored):
  - counter_out<=load_value and reload_reg<=load_value.
  - load_value!=0: state<=COUNT. load_value==0: state<=IDLE.
  - tc_pulse<=0, even if a terminal event would have occurred that cycle.
- IDLE: counter holds; enable ignored; leave only via load.
- COUNT, enable=0: hold counter and state; tc_pulse<=0.
- COUNT, enable=1, counter_out>1: counter_out<=counter_out-1; tc_pulse<=0.
- COUNT, enable=1, counter_out==1 (terminal event), tc_pulse<=1 for exactly one cycle:
  - auto_reload=1: counter_out<=reload_reg; stay COUNT.
  - auto_reload=0: counter_out<=0; state<=EXPIRED.
- Periods:
  - Auto-reload: period = reload_reg enabled cycles; counter never shows 0.
  - reload_reg==1 with auto_reload=1: tc_pulse high on every enabled cycle.
- EXPIRED: counter_out holds 0; enable and auto_reload ignored; tc_pulse<=0; leave only via load.
- No underflow: counter never decrements below 0 and never wraps to 2^WIDTH-1.
- Latency:
  - Load visible on counter_out one cycle after load edge.
  - tc_pulse asserted in the same cycle counter_out shows 0 (one-shot) or the reload value (auto).
- Arithmetic: unsigned, WIDTH bits. Max load 2^WIDTH-1 (15 at default) gives 15 enabled cycles to terminal.
- Changing auto_reload mid-count takes effect at the next terminal event.
- Outputs are glitch-free registered values; no combinational input-to-output paths.

Test Plan:
- Reset: drive reset=0 mid-count with counter_out=7 -> counter_out=0, busy=0, expired=0, tc_pulse=0 immediately, without waiting for a clock edge; after release, stays IDLE until load.
- One-shot: load_value=5, auto_reload=0, load 1 cycle, enable=1 -> counter_out 5,4,3,2,1,0; tc_pulse=1 only in the cycle counter_out=0; expired=1 thereafter; counter stays 0 for 10 more cycles.
- Auto-reload: load_value=3, auto_reload=1, enable=1 for 12 cycles -> sequence 3,2,1,3,2,1,...; tc_pulse every 3rd cycle (4 pulses); busy stays 1.
- Enable gating: load 4, toggle enable 1,0,0,1,1,1 -> counter 4,3,3,3,2,1,0; tc_pulse once.
- Load vs terminal: counter_out=1, enable=1, load=1 with load_value=9 on the same edge -> counter_out=9, tc_pulse=0, busy=1.
- Boundaries:
  - load_value=0 -> IDLE, busy=0, no tc_pulse.
  - load_value=15 -> 15 enabled cycles to tc_pulse, no wrap.
  - load_value=1 with auto_reload=1 -> tc_pulse continuously high while enable=1.
